// File: rtl/maze_path_engine.sv
// maze_path_engine: cell position and move-stack datapath for the maze solver,
// with command error flagging and a handshaked replay of the stored path.
module maze_path_engine #(
   parameter int COORD_W = 4,
   parameter int DEPTH = 64,
   parameter int GOAL_X = 2**COORD_W-1,
   parameter int GOAL_Y = 2**COORD_W-1,
   localparam int CNT_W = $clog2(DEPTH+1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clr_i,
   input  logic               fwd_i,
   input  logic               back_i,
   input  logic               dir_inc_i,
   input  logic               replay_start_i,
   input  logic               replay_ready_i,
   output logic [COORD_W-1:0] x_o,
   output logic [COORD_W-1:0] y_o,
   output logic [1:0]         dir_cnt_o,
   output logic               dir_last_o,
   output logic               lim_n_o,
   output logic               lim_e_o,
   output logic               lim_w_o,
   output logic               lim_s_o,
   output logic               at_goal_o,
   output logic               empty_o,
   output logic               full_o,
   output logic [CNT_W-1:0]   count_o,
   output logic               err_o,
   output logic               replay_valid_o,
   output logic [1:0]         replay_dir_o,
   output logic               replay_done_o
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [COORD_W-1:0] MAXC = '1;
   typedef enum logic {IDLE, REPLAY} state_t;
   state_t state_q, state_d;
   logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
   logic [1:0] dir_q, dir_d, sdir, top, rdir;
   logic [CNT_W-1:0] cnt_q, cnt_d, rd_q, rd_d, cnt_m1;
   logic err_q, err_d, done_q, done_d, push, step, multi, lim_sel;
   logic [1:0] mem [DEPTH];
   assign cnt_m1 = cnt_q - CNT_W'(1);
   assign top = mem[cnt_m1[PTR_W-1:0]];
   assign rdir = mem[rd_q[PTR_W-1:0]];
   assign lim_n_o = y_q == '0;
   assign lim_e_o = x_q == MAXC;
   assign lim_w_o = x_q == '0;
   assign lim_s_o = y_q == MAXC;
   assign lim_sel = dir_q == 2'd0 ? lim_n_o : dir_q == 2'd1 ? lim_e_o : dir_q == 2'd2 ? lim_w_o : lim_s_o;
   assign at_goal_o = x_q == COORD_W'(GOAL_X) && y_q == COORD_W'(GOAL_Y);
   assign empty_o = cnt_q == '0;
   assign full_o = cnt_q == CNT_W'(DEPTH);
   assign dir_last_o = dir_q == 2'd3;
   assign x_o = x_q;
   assign y_o = y_q;
   assign dir_cnt_o = dir_q;
   assign count_o = cnt_q;
   assign err_o = err_q;
   assign replay_done_o = done_q;
   assign replay_valid_o = state_q == REPLAY;
   assign replay_dir_o = replay_valid_o ? rdir : 2'd0;
   assign multi = (fwd_i & back_i) | (fwd_i & replay_start_i) | (back_i & replay_start_i);
   always_comb begin
      state_d = state_q;
      x_d = x_q;
      y_d = y_q;
      dir_d = dir_q;
      cnt_d = cnt_q;
      rd_d = rd_q;
      err_d = 1'b0;
      done_d = 1'b0;
      push = 1'b0;
      step = 1'b0;
      sdir = dir_q;
      if (state_q == IDLE) begin
         if (multi) err_d = 1'b1;
         else begin
            if (dir_inc_i) dir_d = dir_q + 2'd1;
            if (fwd_i) begin
               if (full_o | lim_sel) err_d = 1'b1;
               else begin
                  push = 1'b1;
                  step = 1'b1;
                  cnt_d = cnt_q + CNT_W'(1);
                  dir_d = 2'd0;
               end
            end else if (back_i) begin
               if (empty_o) err_d = 1'b1;
               else begin
                  step = 1'b1;
                  sdir = ~top;
                  cnt_d = cnt_m1;
                  dir_d = top;
               end
            end else if (replay_start_i) begin
               if (empty_o) err_d = 1'b1;
               else begin
                  x_d = '0;
                  y_d = '0;
                  rd_d = '0;
                  state_d = REPLAY;
               end
            end
         end
      end else begin
         err_d = fwd_i | back_i | dir_inc_i | replay_start_i;
         if (replay_ready_i) begin
            step = 1'b1;
            sdir = rdir;
            rd_d = rd_q + CNT_W'(1);
            if (rd_q == cnt_m1) begin
               done_d = 1'b1;
               state_d = IDLE;
            end
         end
      end
      // legal moves are always in bounds, so plain +/-1 never wraps
      if (step) begin
         x_d = sdir == 2'd1 ? x_q + COORD_W'(1) : sdir == 2'd2 ? x_q - COORD_W'(1) : x_q;
         y_d = sdir == 2'd3 ? y_q + COORD_W'(1) : sdir == 2'd0 ? y_q - COORD_W'(1) : y_q;
      end
      if (clr_i) begin
         state_d = IDLE;
         x_d = '0;
         y_d = '0;
         dir_d = 2'd0;
         cnt_d = '0;
         rd_d = '0;
         err_d = 1'b0;
         done_d = 1'b0;
         push = 1'b0;
      end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         x_q <= '0;
         y_q <= '0;
         dir_q <= 2'd0;
         cnt_q <= '0;
         rd_q <= '0;
         err_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         state_q <= state_d;
         x_q <= x_d;
         y_q <= y_d;
         dir_q <= dir_d;
         cnt_q <= cnt_d;
         rd_q <= rd_d;
         err_q <= err_d;
         done_q <= done_d;
      end
   end
   always_ff @(posedge clk) begin
      if (push) mem[cnt_q[PTR_W-1:0]] <= dir_q;
   end
endmodule

// File: tb/tb_maze_path_engine.sv
// tb_maze_path_engine: directed command vectors with hand-derived expected state,
// queued per cycle and checked by an independent monitor.
module tb_maze_path_engine;
   logic clk = 1'b0, rst = 1'b1;
   logic clr = 0, fwd = 0, back = 0, inc = 0, rs = 0, rdy = 0;
   logic [3:0] x, y;
   logic [1:0] dir, rdir;
   logic [6:0] count;
   logic dir_last, lim_n, lim_e, lim_w, lim_s, at_goal, empty, full, err, rv, done;
   typedef struct packed {
      logic [15:0] id;
      logic [3:0] x, y;
      logic [1:0] d;
      logic [6:0] c;
      logic e, v;
      logic [1:0] r;
      logic dn;
   } exp_t;
   exp_t q[$];
   int checks = 0, errors = 0, n_id = 0;
   localparam logic [5:0] C = 6'b100000, F = 6'b010000, B = 6'b001000, I = 6'b000100, R = 6'b000010, Y = 6'b000001;

   maze_path_engine dut (
      .clk(clk), .rst(rst), .clr_i(clr), .fwd_i(fwd), .back_i(back), .dir_inc_i(inc),
      .replay_start_i(rs), .replay_ready_i(rdy), .x_o(x), .y_o(y), .dir_cnt_o(dir),
      .dir_last_o(dir_last), .lim_n_o(lim_n), .lim_e_o(lim_e), .lim_w_o(lim_w), .lim_s_o(lim_s),
      .at_goal_o(at_goal), .empty_o(empty), .full_o(full), .count_o(count), .err_o(err),
      .replay_valid_o(rv), .replay_dir_o(rdir), .replay_done_o(done)
   );

   always #5 clk = ~clk;

   task automatic t(input logic [5:0] in, input int ex, input int ey, input int ed, input int ec,
                    input int ee = 0, input int ev = 0, input int er = 0, input int edn = 0);
      exp_t s;
      @(negedge clk);
      {clr, fwd, back, inc, rs, rdy} = in;
      @(posedge clk);
      n_id++;
      s.id = 16'(n_id);
      s.x = 4'(ex);
      s.y = 4'(ey);
      s.d = 2'(ed);
      s.c = 7'(ec);
      s.e = 1'(ee);
      s.v = 1'(ev);
      s.r = 2'(er);
      s.dn = 1'(edn);
      q.push_back(s);
   endtask

   initial begin : monitor
      exp_t s;
      logic [29:0] av, ev;
      forever begin
         @(negedge clk);
         if (q.size() != 0) begin
            s = q.pop_front();
            ev = {s.x, s.y, s.d, s.c, s.e, s.v, s.r, s.dn, s.d == 2'd3, s.y == 4'd0, s.x == 4'd15,
                  s.x == 4'd0, s.y == 4'd15, s.x == 4'd15 && s.y == 4'd15, s.c == 7'd0, s.c == 7'd64};
            av = {x, y, dir, count, err, rv, rdir, done, dir_last, lim_n, lim_e, lim_w, lim_s, at_goal, empty, full};
            checks++;
            if (av !== ev) begin
               errors++;
               $display("FAIL step%0d x/y/dir/cnt/err/rv/rdir/done/flags got %h want %h", s.id, av, ev);
            end
         end
      end
   end

   initial begin
      q.push_back('0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      // three east moves, then unwind them
      t(I, 0,0,1,0); t(F, 1,0,0,1); t(I, 1,0,1,1); t(F, 2,0,0,2); t(I, 2,0,1,2); t(F, 3,0,0,3);
      t(B, 2,0,1,2); t(B, 1,0,1,1); t(B, 0,0,1,0); t(B, 0,0,1,0, 1);
      // north blocked at origin, dir_cnt wrap
      t(I, 0,0,2,0); t(I, 0,0,3,0); t(I, 0,0,0,0); t(F, 0,0,0,0, 1);
      t(I, 0,0,1,0); t(I, 0,0,2,0); t(I, 0,0,3,0); t(I, 0,0,0,0);
      // path E,S,S then backtrack
      t(I, 0,0,1,0); t(F, 1,0,0,1);
      t(I, 1,0,1,1); t(I, 1,0,2,1); t(I, 1,0,3,1); t(F, 1,1,0,2);
      t(I, 1,1,1,2); t(I, 1,1,2,2); t(I, 1,1,3,2); t(F, 1,2,0,3);
      t(B, 1,1,3,2); t(B, 1,0,3,1); t(B, 0,0,1,0); t(B, 0,0,1,0, 1);
      t(F|B, 0,0,1,0, 1);
      // path E,E,S then replay with ready 1,0,1,1
      t(F, 1,0,0,1); t(I, 1,0,1,1); t(F, 2,0,0,2);
      t(I, 2,0,1,2); t(I, 2,0,2,2); t(I, 2,0,3,2); t(F, 2,1,0,3);
      t(R, 0,0,0,3, 0,1,1); t(Y, 1,0,0,3, 0,1,1); t(0, 1,0,0,3, 0,1,1);
      t(Y, 2,0,0,3, 0,1,3); t(Y, 2,1,0,3, 0,0,0,1); t(0, 2,1,0,3);
      // commands rejected during replay, then clr aborts
      t(R, 0,0,0,3, 0,1,1); t(F, 0,0,0,3, 1,1,1); t(I, 0,0,0,3, 1,1,1);
      t(Y, 1,0,0,3, 0,1,1); t(C, 0,0,0,0); t(R, 0,0,0,0, 1);
      // walk to goal, fill the stack, overflow
      for (int i = 0; i < 15; i++) begin
         t(I, i,0,1,i); t(F, i+1,0,0,i+1);
      end
      for (int j = 0; j < 15; j++) begin
         t(I, 15,j,1,15+j); t(I, 15,j,2,15+j); t(I, 15,j,3,15+j); t(F, 15,j+1,0,16+j);
      end
      for (int k = 0; k < 17; k++) begin
         t(F, 15,14,0,31+2*k);
         t(I, 15,14,1,31+2*k); t(I, 15,14,2,31+2*k); t(I, 15,14,3,31+2*k);
         t(F, 15,15,0,32+2*k);
      end
      t(F, 15,15,0,64, 1);
      t(B, 15,14,3,63);
      t(0, 15,14,3,63);
      for (int w = 0; w < 5 && q.size() != 0; w++) @(negedge clk);
      @(negedge clk);
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain pending %0d want 0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/maze_path_engine.md
# maze_path_engine

Parametrised position/path datapath for the maze-solving controller. It holds the current cell coordinates and a path stack of moves taken, and advances or backtracks one cell per command. It keeps the direction-trial counter the controller sweeps through and flags goal, boundary and stack conditions. Beyond plain solve support, it adds error reporting and a replay mode that re-walks the stored path from the start cell one move per handshake. It sits between the solver FSM and the maze-map/display logic.

## Interface
- COORD_W, 4: coordinate width; the maze is 2**COORD_W x 2**COORD_W cells.
- DEPTH, 64: path stack entries (moves); CNT_W = clog2(DEPTH+1).
- GOAL_X, 2**COORD_W-1: goal column.
- GOAL_Y, 2**COORD_W-1: goal row.
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- clr  in  1  synchronous clear: position to (0,0), stack empty, dir_cnt 0, FSM to IDLE.
- fwd  in  1  push the move `dir_cnt` and step in that direction.
- back  in  1  pop the top move, step in the inverse direction, load `dir_cnt` with the popped move.
- dir_inc  in  1  dir_cnt <= dir_cnt + 1, wrapping modulo 4.
- replay_start  in  1  begin path replay.
- replay_ready  in  1  consumer accepts the current replay move.
- x, y  out  COORD_W  current cell.
- dir_cnt  out  2  direction under trial.
- dir_last  out  1  dir_cnt == 3.
- lim_n, lim_e, lim_w, lim_s  out  1  a step in that direction would leave the maze (y==0, x==max, x==0, y==max).
- at_goal  out  1  x==GOAL_X && y==GOAL_Y.
- empty, full  out  1  stack count == 0 / == DEPTH.
- count  out  CNT_W  moves stored.
- err  out  1  one-cycle pulse on a rejected command.
- replay_valid  out  1  replay move available.
- replay_dir  out  2  replay move.
- replay_done  out  1  one-cycle pulse after the last move is accepted.

## Operation
- Direction code: 00 north (y-1), 01 east (x+1), 10 west (x-1), 11 south (y+1). The inverse of d is ~d.
- FSM states: IDLE, REPLAY. Reset and clr force IDLE.
- IDLE, commands are evaluated together; exactly one of fwd/back/replay_start may be active, otherwise err pulses and nothing changes.
  - fwd: rejected with err if full, or if the lim_* flag for dir_cnt is set. Otherwise stack[count] <= dir_cnt, count+1, position steps, dir_cnt <= 0.
  - back: rejected with err if empty. Otherwise d = stack[count-1], count-1, position steps by ~d, dir_cnt <= d.
  - dir_inc is independent of fwd/back. When it coincides with back or fwd, the load from back/fwd wins.
  - replay_start: rejected with err if empty. Otherwise position <= (0,0), rd_ptr <= 0, go to REPLAY. The stack is preserved.
- REPLAY:
  - replay_valid = 1 and replay_dir = stack[rd_ptr].
  - On replay_valid && replay_ready: position steps by replay_dir and rd_ptr+1.
  - If rd_ptr == count-1 on acceptance, pulse replay_done next cycle and go to IDLE.
  - fwd, back, dir_inc and replay_start in REPLAY pulse err and have no other effect. clr aborts.
- Arithmetic: coordinates never wrap, because a legal move is guaranteed in bounds. count never exceeds DEPTH or goes below 0.
- Flags at_goal, lim_*, empty, full, dir_last and replay_valid are combinational from registered state.

## Timing
- Reset values: x=0, y=0, dir_cnt=0, count=0, empty=1, full=0, err=0, replay_valid=0, replay_dir=0, replay_done=0, state IDLE. at_goal=0 unless GOAL is (0,0).
- Every command takes effect at the clock edge where it is sampled; updated outputs are visible the following cycle. Latency is 1.
- err and replay_done are registered one-cycle pulses asserted the cycle after the triggering edge.
- Replay throughput is one move per cycle while replay_ready is held high. replay_dir holds stable while replay_ready is low.
- rst asserted mid-replay or mid-command returns all state to reset values immediately; stack contents are don't-care.
- clr has priority over all other inputs.

## Test plan
- Reset then fwd with dir_cnt=1 three times -> x=3, y=0, count=3, stack contents 01,01,01, err never asserted.
- At (0,0) with dir_cnt=0, assert fwd -> err pulse, x/y/count unchanged. Then dir_inc x3 -> dir_cnt=3, dir_last=1. Then dir_inc -> dir_cnt=0.
- Path E,S,S, then back -> position (1,1), count=2, dir_cnt=3. Back again -> (1,0), dir_cnt=3. Back on empty -> err.
- With COORD_W=4 and DEPTH=64, move to goal (15,15) -> at_goal=1, lim_e=1, lim_s=1. Filling 64 entries gives full=1, and the next fwd gives err.
- Path E,E,S, then replay_start with replay_ready toggling 1,0,1,1:
  - replay_dir sequence is 01,01,11.
  - Position goes (0,0) to (2,1).
  - replay_done pulses once, then the FSM is back in IDLE with count=3.
- fwd and back asserted together -> err, no state change. clr mid-replay -> IDLE, (0,0), count=0.
